eth_pcs_rx_gearbox: RTL and testbench

- Receive-side 32:66 gearbox between the PMA receive interface and the RX block lock / descrambler.
- Accepts one W_DATA-bit PMA word every cycle and re-frames the bit stream into 66-bit blocks.
- Each block is emitted as two W_DATA words; the sync header is attached to the first word.
- Supports one-bit slips, requested by block lock, to walk the alignment across all 66 bit positions.

---
 rtl/eth_pcs_rx_gearbox_pkg.sv | 22 ++
 rtl/eth_pcs_rx_gearbox_if.sv | 23 ++
 rtl/eth_pcs_rx_gearbox.sv | 120 ++++++++++++
 tb/tb_eth_pcs_rx_gearbox.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pcs_rx_gearbox_pkg.sv
// Shared widths and types for the receive 32:66 gearbox.
// Purely declarative: no logic, no latency, no flow control.
package eth_pcs_rx_gearbox_pkg;
    localparam int W_DATA              = 32;
    localparam int W_SYNC              = 2;
    localparam int W_TRANS_PER_BLK     = 1;
    localparam int W_RX_GEARBOX_BUF    = 66;
    localparam int RX_GEARBOX_HDR_BITS = W_SYNC + W_DATA;
    localparam int W_FILL              = 6;
    localparam int W_ACC               = 7;

    typedef enum logic [W_TRANS_PER_BLK-1:0] {
        TRANS_HDR  = 1'b0,
        TRANS_DATA = 1'b1
    } trans_e;

    typedef struct packed {
        logic [W_SYNC-1:0]          sync_hdr;
        logic [W_DATA-1:0]          data;
        logic [W_TRANS_PER_BLK-1:0] trans_cnt;
    } rx_word_t;
endpackage

// File: rtl/eth_pcs_rx_gearbox_if.sv
// PMA-word / block-word bundle of the receive gearbox.
// master = gearbox side, slave = PMA feed plus block consumer.
interface eth_pcs_rx_gearbox_if;
    import eth_pcs_rx_gearbox_pkg::*;

    logic [W_DATA-1:0]          i_pma_data;
    logic                       i_slip;
    logic                       o_valid;
    logic [W_SYNC-1:0]          o_sync_hdr;
    logic [W_DATA-1:0]          o_data;
    logic [W_TRANS_PER_BLK-1:0] o_trans_cnt;
    logic                       o_slip_done;

    modport master (
        input  i_pma_data, i_slip,
        output o_valid, o_sync_hdr, o_data, o_trans_cnt, o_slip_done
    );

    modport slave (
        output i_pma_data, i_slip,
        input  o_valid, o_sync_hdr, o_data, o_trans_cnt, o_slip_done
    );
endinterface

// File: rtl/eth_pcs_rx_gearbox.sv
// Purpose: re-frames 32-bit PMA words into 66-bit blocks (two words each), with one-bit slip.
// Latency: 1 cycle from accept to o_valid. Backpressure: none, one stall cycle per 33 inputs.
// Optional ETH_PCS_RX_GEARBOX_STATS_EN adds slip/stall counters.
module eth_pcs_rx_gearbox
    import eth_pcs_rx_gearbox_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    eth_pcs_rx_gearbox_if.master  gb
`ifdef ETH_PCS_RX_GEARBOX_STATS_EN
    ,
    output logic [7:0]            o_slip_cnt,
    output logic [15:0]           o_stall_cnt
`endif
);

    logic [W_RX_GEARBOX_BUF-1:0] buf_q, buf_d, acc, acc_s;
    logic [W_FILL-1:0]           fill_q, fill_d;
    logic [W_ACC-1:0]            acc_cnt, acc_cnt_s;
    trans_e                      trans_q, trans_d;
    logic                        slip_pend_q, slip_pend_d, slip_req;
    logic                        emit, slip_apply;
    rx_word_t                    word_d, word_q;
    logic                        valid_q, slip_done_q;

    // Buffer is MSB-aligned: the oldest bit sits at the top, new bits land just below the fill.
    always_comb begin
        acc       = buf_q | ({gb.i_pma_data, {(W_RX_GEARBOX_BUF-W_DATA){1'b0}}} >> fill_q);
        acc_cnt   = W_ACC'(fill_q) + W_ACC'(W_DATA);
        slip_req  = slip_pend_q | gb.i_slip;
        acc_s     = acc;
        acc_cnt_s = acc_cnt;
        buf_d       = acc;
        fill_d      = fill_q;
        trans_d     = trans_q;
        slip_pend_d = slip_req;
        emit        = 1'b0;
        slip_apply  = 1'b0;
        word_d      = '0;
        case (trans_q)
            TRANS_HDR: begin
                slip_pend_d = 1'b0;
                if (slip_req) begin
                    acc_s      = acc << 1;
                    acc_cnt_s  = acc_cnt - W_ACC'(1);
                    slip_apply = 1'b1;
                end
                if (acc_cnt_s >= W_ACC'(RX_GEARBOX_HDR_BITS)) begin
                    emit             = 1'b1;
                    word_d.sync_hdr  = acc_s[W_RX_GEARBOX_BUF-1 -: W_SYNC];
                    word_d.data      = acc_s[W_RX_GEARBOX_BUF-1-W_SYNC -: W_DATA];
                    word_d.trans_cnt = TRANS_HDR;
                    buf_d            = acc_s << RX_GEARBOX_HDR_BITS;
                    fill_d           = W_FILL'(acc_cnt_s - W_ACC'(RX_GEARBOX_HDR_BITS));
                    trans_d          = TRANS_DATA;
                end else begin
                    buf_d  = acc_s;
                    fill_d = W_FILL'(acc_cnt_s);
                end
            end
            default: begin
                emit             = 1'b1;
                word_d.data      = acc[W_RX_GEARBOX_BUF-1 -: W_DATA];
                word_d.trans_cnt = TRANS_DATA;
                buf_d            = acc << W_DATA;
                fill_d           = W_FILL'(acc_cnt - W_ACC'(W_DATA));
                trans_d          = TRANS_HDR;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            buf_q       <= '0;
            fill_q      <= '0;
            trans_q     <= TRANS_HDR;
            slip_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            word_q      <= '0;
            slip_done_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            trans_q     <= trans_d;
            slip_pend_q <= slip_pend_d;
            valid_q     <= emit;
            slip_done_q <= slip_apply;
            if (emit) begin
                word_q <= word_d;
            end
        end
    end

    assign gb.o_valid     = valid_q;
    assign gb.o_sync_hdr  = word_q.sync_hdr;
    assign gb.o_data      = word_q.data;
    assign gb.o_trans_cnt = word_q.trans_cnt;
    assign gb.o_slip_done = slip_done_q;

    // N <= 33 between cycles keeps the appended total within the 66-bit buffer.
    a_acc_bound: assert property (@(posedge i_clk) disable iff (!i_reset)
        acc_cnt <= W_ACC'(W_RX_GEARBOX_BUF - 1));

`ifdef ETH_PCS_RX_GEARBOX_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_slip_cnt  <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (slip_apply && (o_slip_cnt != 8'hFF)) begin
                o_slip_cnt <= o_slip_cnt + 8'd1;
            end
            if ((trans_q == TRANS_HDR) && !emit) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_pcs_rx_gearbox.sv
// Bench for eth_pcs_rx_gearbox: TX-gearbox line model feeding the DUT, a word scoreboard
// and a bit-count control model for o_valid / o_slip_done timing.
module tb_eth_pcs_rx_gearbox;
    import eth_pcs_rx_gearbox_pkg::*;

    typedef struct {
        logic [1:0]  hdr;
        logic [31:0] dat;
        logic        tc;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    eth_pcs_rx_gearbox_if gb_if ();
`ifdef ETH_PCS_RX_GEARBOX_STATS_EN
    logic [7:0]  slip_cnt;
    logic [15:0] stall_cnt;
`endif

    eth_pcs_rx_gearbox dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .gb          (gb_if)
`ifdef ETH_PCS_RX_GEARBOX_STATS_EN
        ,
        .o_slip_cnt  (slip_cnt),
        .o_stall_cnt (stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int   checks = 0;
    int   errors = 0;
    bit   line_q[$];
    exp_t sb_q[$];
    int   blk_idx = 0;
    int   src_mode = 0;
    bit   sb_en = 1'b1;
    bit   align_chk = 1'b0;
    bit   have_d0 = 1'b0;
    logic [31:0] last_d0 = '0;
    bit   last_hdr_word = 1'b0;
    // bit-count model of the gearbox control
    int   m_n = 0, m_t = 0, m_p = 0, m_slips = 0, m_stalls = 0;
    int   obs_valid = 0, obs_stalls = 0, obs_slip_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic gen_block();
        logic [1:0]  h;
        logic [31:0] d0, d1;
        logic [65:0] blk;
        if (src_mode == 0) begin
            h = 2'b01; d0 = 32'h0000_0000; d1 = 32'hFFFF_FFFF;
        end else begin
            h  = blk_idx[0] ? 2'b10 : 2'b01;
            d0 = 32'h5A00_0000 + 32'(2 * blk_idx);
            d1 = d0 + 32'd1;
        end
        blk = {h, d0, d1};
        for (int i = 65; i >= 0; i--) line_q.push_back(blk[i]);
        sb_q.push_back('{h, d0, 1'b0});
        sb_q.push_back('{2'b00, d1, 1'b1});
        blk_idx++;
    endtask

    task automatic step(input bit slip, input bit rst_n);
        logic [31:0] w;
        int a;
        bit exp_valid, exp_sd, exp_tc, eff;
        exp_t e;
        exp_valid = 1'b0; exp_sd = 1'b0; exp_tc = 1'b0;
        if (rst_n) begin
            while (line_q.size() < 32) gen_block();
            for (int i = 31; i >= 0; i--) w[i] = line_q.pop_front();
        end else begin
            w = $urandom;
        end
        gb_if.i_pma_data = w;
        gb_if.i_slip     = slip;
        i_reset          = rst_n;
        if (!rst_n) begin
            m_n = 0; m_t = 0; m_p = 0; m_slips = 0; m_stalls = 0;
        end else begin
            a   = m_n + 32;
            eff = (m_p != 0) || slip;
            if (m_t == 0) begin
                m_p = 0;
                if (eff) begin a--; exp_sd = 1'b1; m_slips++; end
                if (a >= 34) begin exp_valid = 1'b1; exp_tc = 1'b0; a -= 34; m_t = 1; end
                else m_stalls++;
            end else begin
                m_p = eff ? 1 : 0;
                exp_valid = 1'b1; exp_tc = 1'b1; a -= 32; m_t = 0;
            end
            m_n = a;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        chk("valid", 32'(gb_if.o_valid), 32'(exp_valid));
        chk("slip_done", 32'(gb_if.o_slip_done), 32'(exp_sd));
        if (!rst_n) begin
            chk("rst_sync_hdr", 32'(gb_if.o_sync_hdr), 32'd0);
            chk("rst_data", gb_if.o_data, 32'd0);
            chk("rst_trans_cnt", 32'(gb_if.o_trans_cnt), 32'd0);
        end else if (exp_valid) begin
            chk("trans_cnt", 32'(gb_if.o_trans_cnt), 32'(exp_tc));
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", gb_if.o_data, e.dat);
                    if (!e.tc) chk("sb_sync_hdr", 32'(gb_if.o_sync_hdr), 32'(e.hdr));
                end
            end
            if (align_chk) begin
                if (gb_if.o_trans_cnt == 1'b0) begin
                    chk("hdr_aligned", 32'((gb_if.o_sync_hdr == 2'b01) || (gb_if.o_sync_hdr == 2'b10)), 32'd1);
                    last_d0 = gb_if.o_data; have_d0 = 1'b1;
                end else if (have_d0) begin
                    chk("blk_pair", gb_if.o_data, last_d0 + 32'd1);
                end
            end
        end
        if (rst_n) begin
            if (gb_if.o_valid) obs_valid++;
            else obs_stalls++;
        end
        if (gb_if.o_slip_done) obs_slip_done++;
        last_hdr_word = gb_if.o_valid && (gb_if.o_trans_cnt == 1'b0);
    endtask

    task automatic clear_stream();
        line_q.delete();
        sb_q.delete();
        blk_idx = 0;
    endtask

    task automatic do_reset();
        clear_stream();
        step(1'b0, 1'b0);
        clear_stream();
    endtask

    initial begin
        int s0, v0, sd0, ms0;
        bit found;

        // reset state, then first block of 0/FFFFFFFF words
        src_mode = 0;
        do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("first_valid", 32'(gb_if.o_valid), 32'd1);
        chk("first_hdr", 32'(gb_if.o_sync_hdr), 32'h1);
        chk("first_data", gb_if.o_data, 32'h0000_0000);
        step(1'b0, 1'b1);
        chk("second_data", gb_if.o_data, 32'hFFFF_FFFF);
        repeat (6) step(1'b0, 1'b1);

        // incrementing blocks, steady-state stall rate
        src_mode = 1;
        repeat (14) step(1'b0, 1'b1);
        s0 = obs_stalls; v0 = obs_valid;
        repeat (66) step(1'b0, 1'b1);
        chk("stalls_per_66", 32'(obs_stalls - s0), 32'd2);
        chk("words_per_66", 32'(obs_valid - v0), 32'd64);

        // stream offset by 5 bits, walked into alignment by 5 slips
        do_reset();
        sb_en = 1'b0;
        line_q.push_back(1'b1); line_q.push_back(1'b0); line_q.push_back(1'b1);
        line_q.push_back(1'b1); line_q.push_back(1'b0);
        repeat (6) step(1'b0, 1'b1);
        sd0 = obs_slip_done;
        repeat (5) begin
            step(1'b1, 1'b1);
            repeat (3) step(1'b0, 1'b1);
        end
        repeat (6) step(1'b0, 1'b1);
        chk("offset_slip_done_cnt", 32'(obs_slip_done - sd0), 32'd5);
        align_chk = 1'b1; have_d0 = 1'b0;
        repeat (40) step(1'b0, 1'b1);
        align_chk = 1'b0;

        // slip held high for 10 cycles
        sd0 = obs_slip_done; ms0 = m_slips;
        repeat (10) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        chk("held_slip_cnt", 32'(obs_slip_done - sd0), 32'(m_slips - ms0));
        chk("held_slip_min", 32'((obs_slip_done - sd0) >= 5), 32'd1);

        // reset in the middle of a block
        do_reset();
        sb_en = 1'b1;
        repeat (9) step(1'b0, 1'b1);
        found = last_hdr_word;
        for (int i = 0; i < 4 && !found; i++) begin
            step(1'b0, 1'b1);
            found = last_hdr_word;
        end
        chk("mid_block_wait", 32'(found), 32'd1);
        step(1'b0, 1'b0);
        clear_stream();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rerst_first_valid", 32'(gb_if.o_valid), 32'd1);
        chk("rerst_first_trans", 32'(gb_if.o_trans_cnt), 32'd0);
        repeat (20) step(1'b0, 1'b1);

`ifdef ETH_PCS_RX_GEARBOX_STATS_EN
        // saturating slip counter and wrapping stall counter
        do_reset();
        sb_en = 1'b0;
        chk("stats_rst_slip", 32'(slip_cnt), 32'd0);
        chk("stats_rst_stall", 32'(stall_cnt), 32'd0);
        repeat (700) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        chk("stats_slips_ge_300", 32'(m_slips >= 300), 32'd1);
        chk("stats_slip_cnt", 32'(slip_cnt), (m_slips > 255) ? 32'd255 : 32'(m_slips));
        chk("stats_stall_cnt", 32'(stall_cnt), 32'(m_stalls & 16'hFFFF));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
